// File: rtl/uart_rx_engine_if.sv
// Bus-side view of the UART receive engine: FIFO pop/head, status flags
// and overrun clear. master = register/bus block, slave = rx engine.
interface uart_rx_engine_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             rd_en;
   logic             clr_overrun;
   logic [7:0]       rbr_o;
   logic [2:0]       err_o;
   logic             rx_fifo_empty;
   logic             rx_fifo_full;
   logic [LVL_W-1:0] rx_level;
   logic             overrun_o;
   logic             timeout_o;

   modport master (
      output rd_en, clr_overrun,
      input  rbr_o, err_o, rx_fifo_empty, rx_fifo_full, rx_level,
             overrun_o, timeout_o
   );

   modport slave (
      input  rd_en, clr_overrun,
      output rbr_o, err_o, rx_fifo_empty, rx_fifo_full, rx_level,
             overrun_o, timeout_o
   );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive path: 2-FF synchroniser, 13x/16x oversampled frame FSM with
// 3-sample majority vote, parity/framing/break tagging, show-ahead RX FIFO,
// sticky overrun and character timeout.
module uart_rx_engine #(
   parameter int FIFO_DEPTH   = 16,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             baud_tick,
   input  logic             OSM_SEL,
   input  logic [1:0]       WLS,
   input  logic             PEN,
   input  logic             EPS,
   input  logic             STB,
   input  logic             uart_rx_i,
   uart_rx_engine_if.slave  bus
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int TO_W  = $clog2(TIMEOUT_BITS * 16 + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

   // Receiver only ever checks the first stop bit, so STB has no effect.
   logic unused_stb;
   assign unused_stb = STB;

   state_t      state;
   logic        sync1, rx_s;
   logic [3:0]  tick_cnt;
   logic [2:0]  bit_cnt;
   logic        s0, s1;
   logic [7:0]  data_q;
   logic        par_q;
   logic        any_one;
   logic        push_q;
   logic [7:0]  push_data;
   logic [2:0]  push_err;

   logic [3:0]  osr_last, smp_a, smp_b, smp_c;
   logic [2:0]  last_bit;
   logic        vote, par_err;

   assign osr_last = OSM_SEL ? 4'd12 : 4'd15;
   assign smp_a    = OSM_SEL ? 4'd5  : 4'd7;
   assign smp_b    = OSM_SEL ? 4'd6  : 4'd8;
   assign smp_c    = OSM_SEL ? 4'd7  : 4'd9;
   assign last_bit = 3'd4 + {1'b0, WLS};
   // Third sample is taken live on the vote tick.
   assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   assign par_err  = PEN & (EPS ? (^data_q ^ par_q) : ~(^data_q ^ par_q));

   // Two-flop synchroniser, idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= uart_rx_i;
         rx_s  <= sync1;
      end
   end

   // Frame FSM: bit timing, majority vote, error tagging and push request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         s0        <= 1'b1;
         s1        <= 1'b1;
         data_q    <= '0;
         par_q     <= 1'b0;
         any_one   <= 1'b0;
         push_q    <= 1'b0;
         push_data <= '0;
         push_err  <= '0;
      end else begin
         push_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
               end
            end
            BRK_WAIT: begin
               if (rx_s) state <= IDLE;
            end
            default: begin
               if (baud_tick) begin
                  tick_cnt <= (tick_cnt == osr_last) ? 4'd0 : tick_cnt + 4'd1;
                  if (tick_cnt == smp_a) s0 <= rx_s;
                  if (tick_cnt == smp_b) s1 <= rx_s;
                  case (state)
                     START: begin
                        if (tick_cnt == smp_c && vote) begin
                           state <= IDLE;               // false start
                        end else if (tick_cnt == osr_last) begin
                           state   <= DATA;
                           bit_cnt <= '0;
                           data_q  <= '0;
                           any_one <= 1'b0;
                        end
                     end
                     DATA: begin
                        if (tick_cnt == smp_c) begin
                           data_q[bit_cnt] <= vote;
                           if (vote) any_one <= 1'b1;
                        end
                        if (tick_cnt == osr_last) begin
                           if (bit_cnt == last_bit) state <= PEN ? PARITY : STOP;
                           else bit_cnt <= bit_cnt + 3'd1;
                        end
                     end
                     PARITY: begin
                        if (tick_cnt == smp_c) begin
                           par_q <= vote;
                           if (vote) any_one <= 1'b1;
                        end
                        if (tick_cnt == osr_last) state <= STOP;
                     end
                     STOP: begin
                        if (tick_cnt == smp_c) begin
                           push_q <= 1'b1;
                           if (!vote && !any_one) begin
                              push_data <= '0;
                              push_err  <= 3'b110;
                              state     <= BRK_WAIT;
                           end else begin
                              push_data <= data_q;
                              push_err  <= {1'b0, ~vote, par_err};
                              state     <= IDLE;
                           end
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [10:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LVL_W-1:0] count;
   logic             empty, full, do_pop, do_push, overrun;

   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(FIFO_DEPTH));
   assign do_pop  = bus.rd_en && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_q && (!full || do_pop);

   // Storage array, no reset needed: head output is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {push_err, push_data};
   end

   // Pointers, occupancy and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: ;
         endcase
         if (push_q && full && !do_pop) overrun <= 1'b1;
         else if (bus.clr_overrun)      overrun <= 1'b0;
      end
   end

   // ---------------- character timeout ----------------
   logic [TO_W-1:0] to_cnt, to_thr;
   logic            timeout;

   assign to_thr = OSM_SEL ? TO_W'(TIMEOUT_BITS * 13) : TO_W'(TIMEOUT_BITS * 16);

   // Count idle oversample ticks while data sits unread
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (push_q || bus.rd_en || empty)
            to_cnt <= '0;
         else if (baud_tick && state == IDLE && to_cnt != to_thr)
            to_cnt <= to_cnt + TO_W'(1);
         if (push_q || bus.rd_en)  timeout <= 1'b0;
         else if (to_cnt == to_thr) timeout <= 1'b1;
      end
   end

   assign bus.rbr_o         = empty ? 8'h00 : mem[rd_ptr][7:0];
   assign bus.err_o         = empty ? 3'b000 : mem[rd_ptr][10:8];
   assign bus.rx_fifo_empty = empty;
   assign bus.rx_fifo_full  = full;
   assign bus.rx_level      = count;
   assign bus.overrun_o     = overrun;
   assign bus.timeout_o     = timeout;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: stimulus pushes expected
// {err,data} entries, a monitor pops and compares FIFO head on each read.
module tb_uart_rx_engine;
   localparam int DEPTH    = 16;
   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n, baud_tick, OSM_SEL, PEN, EPS, STB, uart_rx_i;
   logic [1:0] WLS;

   uart_rx_engine_if #(.FIFO_DEPTH(DEPTH)) bus();

   uart_rx_engine #(.FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(40)) dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .OSM_SEL(OSM_SEL),
      .WLS(WLS), .PEN(PEN), .EPS(EPS), .STB(STB), .uart_rx_i(uart_rx_i),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cur_osr = 16;
   bit auto_rd = 0, pop_on_push = 0, pop_done = 0;
   logic [10:0] exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Oversample tick: one clock in every TICK_DIV
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // Monitor: reads the head whenever reading is enabled and compares it
   initial begin
      logic [10:0] e;
      bus.rd_en = 1'b0;
      forever begin
         @(negedge clk);
         bus.rd_en = 1'b0;
         if (!bus.rx_fifo_empty && (auto_rd || (pop_on_push && dut.push_q))) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL fifo_entry: got 0x%0h expected no entry",
                        {bus.err_o, bus.rbr_o});
            end else begin
               e = exp_q.pop_front();
               chk("fifo_head", {bus.err_o, bus.rbr_o}, e);
            end
            bus.rd_en = 1'b1;
            if (pop_on_push) begin
               pop_on_push = 0;
               pop_done    = 1;
            end
         end
      end
   end

   task automatic bits_wait(input int n);
      repeat (n * cur_osr * TICK_DIV) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      uart_rx_i = b;
      bits_wait(1);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                             input bit par, input bit stp);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (pen) send_bit(par);
      send_bit(stp);
      uart_rx_i = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      auto_rd = 1;
      while ((!bus.rx_fifo_empty || exp_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, int'(n < 400), 1);
      auto_rd = 0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; uart_rx_i = 1'b1; OSM_SEL = 1'b0; WLS = 2'b11;
      PEN = 1'b0; EPS = 1'b0; STB = 1'b0; bus.clr_overrun = 1'b0;
      repeat (5) @(negedge clk);
      // reset state
      chk("rst_empty",   bus.rx_fifo_empty, 1);
      chk("rst_full",    bus.rx_fifo_full, 0);
      chk("rst_level",   bus.rx_level, 0);
      chk("rst_overrun", bus.overrun_o, 0);
      chk("rst_timeout", bus.timeout_o, 0);
      chk("rst_head",    {bus.err_o, bus.rbr_o}, 0);
      rst_n = 1'b1;
      bits_wait(2);

      // 16x 8N1, 0xA5
      exp_q.push_back({3'b000, 8'hA5});
      send_frame(8'hA5, 8, 0, 0, 1);
      chk("a5_level", bus.rx_level, 1);
      drain("a5");
      chk("a5_empty", bus.rx_fifo_empty, 1);

      // 13x 7E1, 0x35 (four ones): parity 1 -> error, parity 0 -> clean
      OSM_SEL = 1'b1; cur_osr = 13; WLS = 2'b10; PEN = 1'b1; EPS = 1'b1;
      bits_wait(2);
      auto_rd = 1;
      exp_q.push_back({3'b001, 8'h35});
      send_frame(8'h35, 7, 1, 1, 1);
      exp_q.push_back({3'b000, 8'h35});
      send_frame(8'h35, 7, 1, 0, 1);
      bits_wait(1);
      drain("par");

      // 3-tick low glitch on idle line: false start, nothing pushed
      OSM_SEL = 1'b0; cur_osr = 16; WLS = 2'b11; PEN = 1'b0;
      bits_wait(2);
      uart_rx_i = 1'b0;
      repeat (3 * TICK_DIV) @(negedge clk);
      uart_rx_i = 1'b1;
      bits_wait(20);
      chk("glitch_empty", bus.rx_fifo_empty, 1);
      chk("glitch_level", bus.rx_level, 0);
      exp_q.push_back({3'b000, 8'h3C});
      send_frame(8'h3C, 8, 0, 0, 1);
      drain("post_glitch");

      // Break: 8O1, line low for two frames -> single 0x00 / 110 entry
      PEN = 1'b1; EPS = 1'b0;
      bits_wait(2);
      exp_q.push_back({3'b110, 8'h00});
      uart_rx_i = 1'b0;
      bits_wait(22);
      chk("brk_level_low", bus.rx_level, 1);
      uart_rx_i = 1'b1;
      bits_wait(2);
      chk("brk_level_high", bus.rx_level, 1);
      drain("brk");
      // 0x00 with odd parity bit 1 is a clean character
      exp_q.push_back({3'b000, 8'h00});
      send_frame(8'h00, 8, 1, 1, 1);
      drain("post_brk");

      // Overrun: 17 chars, no reads; 17th dropped
      PEN = 1'b0;
      bits_wait(2);
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (i < DEPTH) exp_q.push_back({3'b000, 8'(8'h40 + i)});
         send_frame(8'(8'h40 + i), 8, 0, 0, 1);
      end
      bits_wait(1);
      chk("ovr_full",    bus.rx_fifo_full, 1);
      chk("ovr_level",   bus.rx_level, DEPTH);
      chk("ovr_overrun", bus.overrun_o, 1);
      bus.clr_overrun = 1'b1;
      @(negedge clk);
      bus.clr_overrun = 1'b0;
      chk("ovr_cleared", bus.overrun_o, 0);
      // one more char with a read in the push cycle
      exp_q.push_back({3'b000, 8'h77});
      pop_done = 0;
      pop_on_push = 1;
      send_frame(8'h77, 8, 0, 0, 1);
      bits_wait(1);
      chk("pp_pop_done", int'(pop_done), 1);
      pop_on_push = 0;
      chk("pp_overrun", bus.overrun_o, 0);
      chk("pp_level",   bus.rx_level, DEPTH);
      chk("pp_full",    bus.rx_fifo_full, 1);
      drain("ovr");
      chk("ovr_q_left", exp_q.size(), 0);

      // Timeout: one char then 40 bit-times of idle
      exp_q.push_back({3'b000, 8'h5A});
      send_frame(8'h5A, 8, 0, 0, 1);
      repeat (600 * TICK_DIV) @(negedge clk);
      chk("to_early", bus.timeout_o, 0);
      repeat (60 * TICK_DIV) @(negedge clk);
      chk("to_set", bus.timeout_o, 1);
      drain("to");
      chk("to_cleared", bus.timeout_o, 0);
      chk("to_empty",   bus.rx_fifo_empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
